sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display.
- Sequences one anode at a time, decodes a hex nibble per digit, and applies per-digit decimal point and blanking.
- Provides 16-level brightness through PWM within each digit slot.
- Accepts new display contents over a valid/ready handshake and applies them only at frame boundaries, so the display never tears.
- Sits between system logic and the sseg_out/dp_out/an_out pins; runs on sys_clk.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes scanned (2..8).
- PHASE_LEN, 1562, sys_clk cycles per PWM phase; one digit slot is 16 phases; frame = NUM_DIGITS*16*PHASE_LEN cycles (~1 kHz at 200 MHz).

Ports:
- clk_in  input  1  system clock.
- rst_low_in  input  1  asynchronous active-low reset.
- data_in  input  4*NUM_DIGITS  hex nibble per digit; digit k = data_in[4k+3:4k].
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  input  NUM_DIGITS  1 = digit fully dark (segments and dp).
- valid_in  input  1  update request; data_in/dp_in/blank_in are valid.
- ready_out  output  1  pending buffer empty; an update is accepted when valid_in and ready_out are both high.
- bright_in  input  4  brightness; sampled live, not through the handshake.
- sseg_out  output  7  segments, active-low; bit0 = a … bit6 = g.
- dp_out  output  1  decimal point, active-low.
- an_out  output  NUM_DIGITS  anodes, active-low; bit k = digit k.
- frame_out  output  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async, rst_low_in = 0):
  - an_out = all 1s, sseg_out = 7'h7F, dp_out = 1, frame_out = 0, ready_out = 1.
  - Counters are 0; the active register is cleared with blank = all 1s; the pending register is empty.
  - Reset mid-frame or mid-handshake discards pending data; no output glitches other than going dark.
- Counters:
  - phase_cnt runs 0..PHASE_LEN-1.
  - On wrap of phase_cnt, phase increments 0..15.
  - On wrap of phase from 15 to 0, digit increments 0..NUM_DIGITS-1, then wraps to 0.
- Frame boundary = the cycle where digit wraps from NUM_DIGITS-1 to 0.
  - frame_out = 1 in exactly that cycle.
  - If pending is full, pending is copied to active in that cycle and ready_out returns to 1 the next cycle.
- Handshake:
  - When valid_in & ready_out, data/dp/blank are captured into pending and ready_out goes to 0 the next cycle.
  - ready_out stays 0 until the pending data is applied at the frame boundary.
  - A capture in the frame-boundary cycle itself (pending was empty) is applied at the next boundary, not bypassed.
  - valid_in while ready_out = 0 is ignored; the source holds valid_in.
  - Maximum update rate is one per frame.
- Lit condition for the current digit: phase <= bright_in and active blank[digit] = 0.
  - bright_in = 15 gives 16/16 duty; bright_in = 0 gives 1/16 duty.
  - A bright_in change takes effect on the next phase comparison.
- Output registers (one cycle after the counter state):
  - an_out: only bit digit is 0 when lit, all 1s otherwise.
  - sseg_out: ~decode(nibble) when lit, 7'h7F otherwise.
  - dp_out: ~dp[digit] when lit, 1 otherwise.
  - Anode and segment values change on the same edge.
- Decode, active-high gfedcba before inversion:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- No more than one anode is ever low.

Test Plan:
- Reset: hold rst_low_in = 0 for 5 cycles, release, run one frame -> an_out = 8'hFF, sseg_out = 7'h7F, dp_out = 1 throughout; ready_out = 1; frame_out pulses once per 256 cycles.
  - Frame period is for NUM_DIGITS = 4, PHASE_LEN = 4; the remaining scenarios use the same parameters.
- Handshake latency: push data_in = 16'h3210, dp_in = 4'b0100, blank_in = 0, bright_in = 15 mid-frame -> ready_out = 0 the next cycle; at the next frame_out, ready_out returns to 1.
  - Digit 0 shows sseg_out = ~3F = 7'h40 with an_out = 4'b1110 for 64 cycles.
  - Digit 2 shows sseg_out = ~5B = 7'h24 with dp_out = 0.
- Tearing protection: while ready_out = 0, drive valid_in with 16'hFFFF -> the display keeps 3210 for the rest of the frame.
  - The second update is accepted only after ready_out = 1, and appears one frame later.
- Brightness: bright_in = 3 -> each digit is lit for 16 cycles (phases 0–3) and dark for 48 cycles of its 64-cycle slot.
  - bright_in = 0 -> lit for 4 cycles per slot.
- Blanking/wrap: blank_in = 4'b1010 -> an_out bits 1 and 3 never go low; digit index wraps 3 -> 0 with frame_out high in the wrap cycle.
- Async reset mid-handshake: assert rst_low_in while ready_out = 0 -> outputs go dark immediately with no clock edge; after release, ready_out = 1, the old pending data is never displayed, and the display stays dark.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_ctrl
//  Purpose  : Multiplexed seven-segment scan controller with PWM brightness
//             and frame-synchronous (tear-free) display updates.
//  Revision : 1.0  initial release
// ============================================================================
module sseg_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int PHASE_LEN  = 1562
) (
   input  logic                    clk_in,
   input  logic                    rst_low_in,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    valid_in,
   output logic                    ready_out,
   input  logic [3:0]              bright_in,
   output logic [6:0]              sseg_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    frame_out
);

   localparam int c_PC_W  = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
   localparam int c_DIG_W = $clog2(NUM_DIGITS);
   localparam logic [c_PC_W-1:0]  c_PC_LAST  = c_PC_W'(PHASE_LEN - 1);
   localparam logic [c_DIG_W-1:0] c_DIG_LAST = c_DIG_W'(NUM_DIGITS - 1);

   // Active-high gfedcba pattern for a hex nibble.
   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   logic [c_PC_W-1:0]       r_phase_cnt;
   logic [3:0]              r_phase;
   logic [c_DIG_W-1:0]      r_digit;

   logic                    r_full;
   logic [4*NUM_DIGITS-1:0] r_pend_data;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic [NUM_DIGITS-1:0]   r_pend_blank;
   logic [4*NUM_DIGITS-1:0] r_act_data;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_blank;

   logic [NUM_DIGITS-1:0]   r_an;
   logic [6:0]              r_seg;
   logic                    r_dp;

   logic                    w_pc_wrap;
   logic                    w_ph_wrap;
   logic                    w_frame;
   logic                    w_accept;
   logic                    w_lit;
   logic [3:0]              w_nibble;
   logic [NUM_DIGITS-1:0]   w_an_nxt;
   logic [6:0]              w_seg_nxt;
   logic                    w_dp_nxt;

   assign w_pc_wrap = (r_phase_cnt == c_PC_LAST);
   assign w_ph_wrap = w_pc_wrap && (r_phase == 4'hF);
   assign w_frame   = w_ph_wrap && (r_digit == c_DIG_LAST);
   assign w_accept  = valid_in && !r_full;

   always_ff @(posedge clk_in or negedge rst_low_in) begin
      if (!rst_low_in) begin
         r_phase_cnt <= '0;
         r_phase     <= '0;
         r_digit     <= '0;
      end else begin
         if (w_pc_wrap) begin
            r_phase_cnt <= '0;
            r_phase     <= r_phase + 4'd1;
         end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
         end
         if (w_ph_wrap) begin
            r_digit <= w_frame ? '0 : r_digit + 1'b1;
         end
      end
   end

   // Pending can only be loaded while empty and only drained while full, so a
   // capture in the boundary cycle always waits for the following frame.
   always_ff @(posedge clk_in or negedge rst_low_in) begin
      if (!rst_low_in) begin
         r_full       <= 1'b0;
         r_pend_data  <= '0;
         r_pend_dp    <= '0;
         r_pend_blank <= '0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_act_blank  <= '1;
      end else begin
         if (w_frame && r_full) begin
            r_act_data  <= r_pend_data;
            r_act_dp    <= r_pend_dp;
            r_act_blank <= r_pend_blank;
            r_full      <= 1'b0;
         end else if (w_accept) begin
            r_pend_data  <= data_in;
            r_pend_dp    <= dp_in;
            r_pend_blank <= blank_in;
            r_full       <= 1'b1;
         end
      end
   end

   assign w_nibble = r_act_data[{r_digit, 2'b00} +: 4];
   assign w_lit    = (r_phase <= bright_in) && !r_act_blank[r_digit];

   always_comb begin
      w_an_nxt  = '1;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
      if (w_lit) begin
         w_an_nxt[r_digit] = 1'b0;
         w_seg_nxt         = ~f_decode(w_nibble);
         w_dp_nxt          = ~r_act_dp[r_digit];
      end
   end

   // Pins are registered so anode and segment lines switch on the same edge.
   always_ff @(posedge clk_in or negedge rst_low_in) begin
      if (!rst_low_in) begin
         r_an  <= '1;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
         r_dp  <= w_dp_nxt;
      end
   end

   assign an_out    = r_an;
   assign sseg_out  = r_seg;
   assign dp_out    = r_dp;
   assign ready_out = !r_full;
   assign frame_out = w_frame;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_ctrl
//  Purpose  : Directed, table-driven bench for sseg_scan_ctrl (4 digits,
//             4-cycle PWM phase, 256-cycle frame).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_ctrl;

   localparam int c_ND = 4;
   localparam int c_PL = 4;

   logic        clk_in = 1'b0;
   logic        rst_low_in = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_in = '0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [3:0]  bright_in = '0;
   logic [6:0]  sseg_out;
   logic        dp_out;
   logic [3:0]  an_out;
   logic        frame_out;

   sseg_scan_ctrl #(.NUM_DIGITS(c_ND), .PHASE_LEN(c_PL)) dut (
      .clk_in     (clk_in),
      .rst_low_in (rst_low_in),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .bright_in  (bright_in),
      .sseg_out   (sseg_out),
      .dp_out     (dp_out),
      .an_out     (an_out),
      .frame_out  (frame_out)
   );

   always #5 clk_in = ~clk_in;

   // seg/dpo hold the expected active-low pin values while a digit is lit.
   typedef struct packed {
      logic [15:0]     data;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic [3:0]      bright;
      logic [3:0][6:0] seg;
      logic [3:0]      dpo;
   } vec_t;

   vec_t tbl [5];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_frame();
      int k = 0;
      while (frame_out !== 1'b1 && k < 600) begin
         @(negedge clk_in);
         k++;
      end
      check("frame_pulse_seen", frame_out, 1);
   endtask

   task automatic push(input vec_t v);
      int k = 0;
      while (ready_out !== 1'b1 && k < 600) begin
         @(negedge clk_in);
         k++;
      end
      data_in   = v.data;
      dp_in     = v.dp;
      blank_in  = v.blank;
      bright_in = v.bright;
      valid_in  = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      check("ready_low_after_accept", ready_out, 0);
   endtask

   // Entered at the first output cycle of a frame; leaves at the same point of the next.
   task automatic check_frame(input int idx, input logic exp_rdy);
      int          lit_cnt [4];
      int          bad [4];
      int          d;
      int          p;
      logic        e_lit;
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp;
      for (int j = 0; j < 4; j++) begin
         lit_cnt[j] = 0;
         bad[j]     = 0;
      end
      for (int i = 0; i < 256; i++) begin
         d     = i / 64;
         p     = (i % 64) / 4;
         e_lit = !tbl[idx].blank[d] && (p <= int'(tbl[idx].bright));
         e_an  = e_lit ? ~(4'b0001 << d) : 4'hF;
         e_seg = e_lit ? tbl[idx].seg[d] : 7'h7F;
         e_dp  = e_lit ? tbl[idx].dpo[d] : 1'b1;
         if (an_out !== e_an || sseg_out !== e_seg || dp_out !== e_dp ||
             frame_out !== (i == 254) || $countones(~an_out) > 1 ||
             (i < 255 && ready_out !== exp_rdy))
            bad[d]++;
         if (an_out !== 4'hF) lit_cnt[d]++;
         if (i == 255) check($sformatf("ready_after_frame_v%0d", idx), ready_out, 1);
         @(negedge clk_in);
      end
      for (int j = 0; j < 4; j++) begin
         check($sformatf("lit_cycles_v%0d_d%0d", idx, j), lit_cnt[j],
               tbl[idx].blank[j] ? 0 : (int'(tbl[idx].bright) + 1) * 4);
         check($sformatf("slot_errors_v%0d_d%0d", idx, j), bad[j], 0);
      end
   endtask

   task automatic run_dark(input string name, input int cycles);
      int dark_bad = 0;
      int nfr      = 0;
      int first    = -1;
      int last     = -1;
      int gap      = 0;
      for (int c = 0; c < cycles; c++) begin
         if (an_out !== 4'hF || sseg_out !== 7'h7F || dp_out !== 1'b1 || ready_out !== 1'b1)
            dark_bad++;
         if (frame_out === 1'b1) begin
            if (first < 0) first = c;
            if (last >= 0) gap = c - last;
            last = c;
            nfr++;
         end
         @(negedge clk_in);
      end
      check({name, "_dark_errors"}, dark_bad, 0);
      check({name, "_frame_count"}, nfr, 2);
      check({name, "_first_frame"}, first, 255);
      check({name, "_frame_period"}, gap, 256);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{16'h3210, 4'b0100, 4'b0000, 4'd15, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1011};
      tbl[1] = '{16'hA5C8, 4'b1001, 4'b0000, 4'd3,  {7'h08, 7'h12, 7'h46, 7'h00}, 4'b0110};
      tbl[2] = '{16'hBDEF, 4'b0000, 4'b1010, 4'd0,  {7'h03, 7'h21, 7'h06, 7'h0E}, 4'b1111};
      tbl[3] = '{16'h7649, 4'b1111, 4'b0001, 4'd7,  {7'h78, 7'h02, 7'h19, 7'h10}, 4'b0000};
      tbl[4] = '{16'hFFFF, 4'b0000, 4'b0000, 4'd15, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 4'b1111};

      rst_low_in = 1'b0;
      repeat (5) @(negedge clk_in);
      check("reset_an", an_out, 4'hF);
      check("reset_sseg", sseg_out, 7'h7F);
      check("reset_dp", dp_out, 1);
      check("reset_ready", ready_out, 1);
      check("reset_frame", frame_out, 0);
      rst_low_in = 1'b1;
      run_dark("post_reset", 512);

      for (int v = 0; v < 4; v++) begin
         push(tbl[v]);
         wait_frame();
         @(negedge clk_in);
         @(negedge clk_in);
         check_frame(v, 1'b1);
      end

      // Second request held while the first is still pending.
      push(tbl[0]);
      data_in  = 16'hFFFF;
      dp_in    = 4'b0000;
      blank_in = 4'b0000;
      valid_in = 1'b1;
      wait_frame();
      @(negedge clk_in);
      check("tear_ready_reopen", ready_out, 1);
      @(negedge clk_in);
      check("tear_second_accept", ready_out, 0);
      valid_in = 1'b0;
      check_frame(0, 1'b0);
      check_frame(4, 1'b1);

      // Asynchronous reset while an update is pending.
      push(tbl[1]);
      check("pre_reset_lit_an", an_out, 4'b1110);
      #2;
      rst_low_in = 1'b0;
      #1;
      check("async_rst_an", an_out, 4'hF);
      check("async_rst_sseg", sseg_out, 7'h7F);
      check("async_rst_dp", dp_out, 1);
      check("async_rst_ready", ready_out, 1);
      repeat (3) @(negedge clk_in);
      rst_low_in = 1'b1;
      run_dark("after_async_rst", 512);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
